// File: rtl/mp0_conv1_wr_ctrl.sv
// Write controller steering maxpool0 pixels into the four conv1 row banks.
// Tracks rows waiting for conv1 and stalls the stream when all banks are full.
module mp0_conv1_wr_ctrl #(
    parameter int BD = 18,
    parameter int W  = 14,
    parameter int H  = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [BD-1:0] in_a,
    input  logic [BD-1:0] in_b,
    input  logic [BD-1:0] in_c,
    output logic          in_ready,
    input  logic          row_consumed,
    output logic          wren0,
    output logic          wren1,
    output logic          wren2,
    output logic          wren3,
    output logic [9:0]    wraddr,
    output logic [BD-1:0] d_a,
    output logic [BD-1:0] d_b,
    output logic [BD-1:0] d_c,
    output logic [2:0]    rows_avail,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [9:0] C_LAST = 10'(W - 1);
    localparam logic [9:0] R_LAST = 10'(H - 1);

    state_t        r_state;
    state_t        w_next;
    logic [9:0]    r_col;
    logic [9:0]    r_row;
    logic [1:0]    r_bank;
    logic [3:0]    r_wren;
    logic [9:0]    r_wraddr;
    logic [BD-1:0] r_da;
    logic [BD-1:0] r_db;
    logic [BD-1:0] r_dc;
    logic [2:0]    r_avail;

    logic w_accept;
    logic w_row_end;
    logic w_frame_end;
    logic w_start;
    logic w_dec;

    assign w_accept    = in_valid & in_ready;
    assign w_row_end   = w_accept & (r_col == C_LAST);
    assign w_frame_end = w_row_end & (r_row == R_LAST);
    assign w_start     = (r_state == S_IDLE) & start & (r_avail == 3'd0);
    assign w_dec       = row_consumed & (r_avail != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_WRITE;
            S_WRITE: if (w_frame_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == S_WRITE) && (r_avail < 3'd4);
        busy       = (r_state == S_WRITE);
        frame_done = (r_state == S_DONE);
    end

    // Pixel is registered; its write appears one cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wren   <= 4'd0;
            r_wraddr <= 10'd0;
            r_da     <= '0;
            r_db     <= '0;
            r_dc     <= '0;
        end else begin
            r_wren <= w_accept ? (4'b0001 << r_bank) : 4'd0;
            if (w_accept) begin
                r_wraddr <= r_col;
                r_da     <= in_a;
                r_db     <= in_b;
                r_dc     <= in_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col  <= 10'd0;
            r_row  <= 10'd0;
            r_bank <= 2'd0;
        end else if (w_start) begin
            r_col  <= 10'd0;
            r_row  <= 10'd0;
            r_bank <= 2'd0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col  <= 10'd0;
                r_row  <= r_row + 10'd1;
                r_bank <= r_bank + 2'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Completion and consumption in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_avail <= 3'd0;
        end else begin
            case ({w_row_end, w_dec})
                2'b10:   r_avail <= r_avail + 3'd1;
                2'b01:   r_avail <= r_avail - 3'd1;
                default: r_avail <= r_avail;
            endcase
        end
    end

    assign wren0      = r_wren[0];
    assign wren1      = r_wren[1];
    assign wren2      = r_wren[2];
    assign wren3      = r_wren[3];
    assign wraddr     = r_wraddr;
    assign d_a        = r_da;
    assign d_b        = r_db;
    assign d_c        = r_dc;
    assign rows_avail = r_avail;

endmodule

// File: tb/tb_mp0_conv1_wr_ctrl.sv
// Bench for mp0_conv1_wr_ctrl: reference model feeds a write scoreboard,
// negedge monitor compares every presented write and status output.
module tb_mp0_conv1_wr_ctrl;

    localparam int BD = 18;
    localparam int W  = 14;
    localparam int H  = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [BD-1:0] in_a;
    logic [BD-1:0] in_b;
    logic [BD-1:0] in_c;
    logic          in_ready;
    logic          row_consumed;
    logic          wren0;
    logic          wren1;
    logic          wren2;
    logic          wren3;
    logic [9:0]    wraddr;
    logic [BD-1:0] d_a;
    logic [BD-1:0] d_b;
    logic [BD-1:0] d_c;
    logic [2:0]    rows_avail;
    logic          busy;
    logic          frame_done;

    mp0_conv1_wr_ctrl #(.BD(BD), .W(W), .H(H)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_a(in_a),
        .in_b(in_b),
        .in_c(in_c),
        .in_ready(in_ready),
        .row_consumed(row_consumed),
        .wren0(wren0),
        .wren1(wren1),
        .wren2(wren2),
        .wren3(wren3),
        .wraddr(wraddr),
        .d_a(d_a),
        .d_b(d_b),
        .d_c(d_c),
        .rows_avail(rows_avail),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            bank;
        int            addr;
        logic [BD-1:0] a;
        logic [BD-1:0] b;
        logic [BD-1:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nwr = 0;
    int   nfd = 0;
    int   cnt_wr[4] = '{0, 0, 0, 0};
    int   n = 0;

    // reference model state (0 idle, 1 write, 2 done)
    int m_st, m_col, m_row, m_bank, m_av;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin : model
        int acc, last, dec, st_n;
        exp_t e;
        if (reset) begin
            m_st   <= 0;
            m_col  <= 0;
            m_row  <= 0;
            m_bank <= 0;
            m_av   <= 0;
            q.delete();
        end else begin
            acc  = (in_valid && m_st == 1 && m_av < 4) ? 1 : 0;
            last = (acc == 1 && m_col == W - 1) ? 1 : 0;
            dec  = (row_consumed && m_av != 0) ? 1 : 0;
            st_n = m_st;
            if (m_st == 0 && start && m_av == 0) st_n = 1;
            if (m_st == 1 && last == 1 && m_row == H - 1) st_n = 2;
            if (m_st == 2) st_n = 0;
            if (acc == 1) begin
                e.bank = m_bank;
                e.addr = m_col;
                e.a = in_a;
                e.b = in_b;
                e.c = in_c;
                q.push_back(e);
            end
            if (last == 1 && dec == 0) m_av <= m_av + 1;
            else if (dec == 1 && last == 0) m_av <= m_av - 1;
            if (m_st == 0 && start && m_av == 0) begin
                m_col  <= 0;
                m_row  <= 0;
                m_bank <= 0;
            end else if (acc == 1) begin
                if (last == 1) begin
                    m_col  <= 0;
                    m_row  <= m_row + 1;
                    m_bank <= (m_bank + 1) % 4;
                end else begin
                    m_col <= m_col + 1;
                end
            end
            m_st <= st_n;
        end
    end

    always @(negedge clk) begin : monitor
        logic [3:0] w;
        exp_t e;
        if (!reset) begin
            w = {wren3, wren2, wren1, wren0};
            check("in_ready", 32'(in_ready),
                  32'(m_st == 1 && m_av < 4));
            check("rows_avail", 32'(rows_avail), 32'(m_av));
            check("busy", 32'(busy), 32'(m_st == 1));
            check("frame_done", 32'(frame_done), 32'(m_st == 2));
            if (w != 4'd0) begin
                nwr++;
                for (int i = 0; i < 4; i++) if (w[i]) cnt_wr[i]++;
                if (q.size() == 0) begin
                    check("unexpected_write", 32'(w), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("wren", 32'(w), 32'(4'b0001 << e.bank));
                    check("wraddr", 32'(wraddr), 32'(e.addr));
                    check("d_a", 32'(d_a), 32'(e.a));
                    check("d_b", 32'(d_b), 32'(e.b));
                    check("d_c", 32'(d_c), 32'(e.c));
                end
            end else begin
                check("missing_write", 32'(q.size()), 32'd0);
            end
            if (frame_done) begin
                nfd++;
                check("fd_with_wren", 32'(w[(H - 1) % 4]), 32'd1);
            end
        end
    end

    task automatic step(input logic v, input logic rc, input logic st);
        in_valid     = v;
        row_consumed = rc;
        start        = st;
        in_a         = BD'(n);
        in_b         = BD'(n + 7000);
        in_c         = BD'(n) ^ 18'h15555;
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_wren"}, 32'({wren3, wren2, wren1, wren0}), 32'd0);
        check({nm, "_wraddr"}, 32'(wraddr), 32'd0);
        check({nm, "_d"}, 32'(d_a | d_b | d_c), 32'd0);
        check({nm, "_avail"}, 32'(rows_avail), 32'd0);
        check({nm, "_flags"}, 32'({in_ready, busy, frame_done}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        row_consumed = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        step(0, 0, 0);

        // first row into bank 0
        step(0, 0, 1);
        for (int i = 0; i < W; i++) step(1, 0, 0);
        check("row0_last_wren0", 32'(wren0), 32'd1);
        check("row0_last_addr", 32'(wraddr), 32'd13);
        check("row0_avail", 32'(rows_avail), 32'd1);
        step(1, 0, 0);
        check("row1_first_wren1", 32'(wren1), 32'd1);
        check("row1_first_addr", 32'(wraddr), 32'd0);

        // fill all four banks, then keep offering pixels
        for (int i = 0; i < 46; i++) step(1, 0, 0);
        check("full_avail", 32'(rows_avail), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_writes", 32'(nwr), 32'd56);
        step(0, 1, 0);
        check("freed_ready", 32'(in_ready), 32'd1);
        check("freed_avail", 32'(rows_avail), 32'd3);
        for (int i = 0; i < W; i++) step(1, 0, 0);
        step(0, 0, 0);
        check("row4_bank0", 32'(cnt_wr[0]), 32'd28);
        check("row4_avail", 32'(rows_avail), 32'd4);

        // completion coincides with consumption at rows_avail=2
        step(0, 1, 0);
        step(0, 1, 0);
        check("pre_coincide", 32'(rows_avail), 32'd2);
        for (int i = 0; i < W - 1; i++) step(1, 0, 0);
        step(1, 1, 0);
        check("coincide_avail", 32'(rows_avail), 32'd2);

        // remaining rows with conv1 consuming one row each
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < W; c++) step(1, c == 0, 0);
        check("done_pulse", 32'(frame_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_wren1", 32'(wren1), 32'd1);
        step(0, 0, 0);
        check("after_done", 32'(frame_done), 32'd0);
        check("frame_writes", 32'(nwr), 32'd196);
        check("frame_fd_count", 32'(nfd), 32'd1);
        check("frame_bank1", 32'(cnt_wr[1]), 32'd56);
        check("frame_bank3", 32'(cnt_wr[3]), 32'd42);

        // start ignored while rows remain
        step(0, 1, 0);
        check("pre_ign_avail", 32'(rows_avail), 32'd1);
        step(0, 0, 1);
        step(0, 0, 0);
        check("ign_start_busy", 32'(busy), 32'd0);
        check("ign_start_avail", 32'(rows_avail), 32'd1);
        step(0, 1, 0);
        step(0, 1, 0);
        check("drained", 32'(rows_avail), 32'd0);

        // new frame, start while busy, then reset at column 7
        step(0, 0, 1);
        check("restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        step(1, 0, 1);
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_addr", 32'(wraddr), 32'd7);
        reset = 1'b1;
        #1;
        check_zero("midrow");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 1);
        step(1, 0, 0);
        check("post_rst_wren0", 32'(wren0), 32'd1);
        check("post_rst_addr", 32'(wraddr), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
